uart_tx_fifo_writer: RTL and testbench

Parametrised next-generation UART transmitter with a built-in TX FIFO. Serialises words of configurable width with optional parity and 1 or 2 stop bits, at a baud rate derived from the system clock. Sits between on-chip producers and the tx pin. Producers push words through a valid/ready handshake instead of waiting for each frame to finish.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/uart_tx_fifo_writer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo_writer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the FIFO-fed UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY_S,
      STOP
   } tx_state_e;

   // Nearest-integer clock divider for one bit period.
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

   function automatic bit cfg_ok(input int data_bits, input int stop_bits, input int depth);
      return (data_bits >= 5) && (data_bits <= 9) &&
             ((stop_bits == 1) || (stop_bits == 2)) &&
             (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign level_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (level_o == (AW+1)'(DEPTH));
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; flushing is done by clearing the pointers.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_fifo_writer.sv
// UART transmitter fed by a small FIFO; frames run back to back while words are queued.
module uart_tx_fifo_writer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int boadrate  = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_BITS-1:0]   data,
   input  logic                   valid,
   output logic                   ready,
   output logic                   tx,
   output logic                   wait_signal,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int             DIV       = calc_div(CLK_FREQ, boadrate);
   localparam int             BCW       = $clog2(DIV);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);
   localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
   localparam parity_e        PMODE     = parity_e'(PARITY);

   if (!cfg_ok(DATA_BITS, STOP_BITS, DEPTH) || (PARITY < 0) || (PARITY > 2) || (DIV < 2)) begin : g_cfg_err
      $error("uart_tx_fifo_writer: illegal parameter combination");
   end

   tx_state_e            state_q, state_d;
   logic [BCW-1:0]       baud_cnt_q, baud_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 pop, bit_end;
   logic                 fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_n_i (rst),
      .push_i  (valid),
      .wdata_i (data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign ready       = !fifo_full;
   assign wait_signal = !fifo_empty || (state_q != IDLE);
   assign tx          = tx_q;
   assign bit_end     = (baud_cnt_q == BAUD_LAST);

   // tx_d reflects the current state, so the line lags the FSM by one clock.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      pop        = 1'b0;
      tx_d       = 1'b1;
      if (state_q != IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + BCW'(1);
      case (state_q)
         IDLE: tx_d = 1'b1;
         START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            tx_d = shreg_q[0];
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = (PMODE == PAR_NONE) ? STOP : PARITY_S;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         PARITY_S: begin
            tx_d = par_q;
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Load from the FIFO whenever the FSM is, or is about to be, idle.
      if ((state_d == IDLE) && !fifo_empty) begin
         pop        = 1'b1;
         shreg_d    = fifo_rdata;
         par_d      = (^fifo_rdata) ^ (PMODE == PAR_ODD);
         state_d    = START;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
   end

endmodule

// File: tb/tb_uart_tx_fifo_writer.sv
// Bench for uart_tx_fifo_writer: four configurations behind one selector, line decoded by a UART receiver model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   int         sel = 0;
   int         cyc = 0;
   bit         mon_en = 1'b0;
   int         total = 0;
   int         bad = 0;

   int cfg_div = 434, cfg_nb = 8, cfg_par = 0, cfg_stop = 1;

   logic       v0, v1, v2, v3;
   logic       tx0, tx1, tx2, tx3;
   logic       rdy0, rdy1, rdy2, rdy3;
   logic       wt0, wt1, wt2, wt3;
   logic [2:0] lv0, lv1, lv2, lv3;
   logic       tx_sel, ready_sel, wait_sel;
   logic [2:0] lvl_sel;

   logic [7:0] rx_w[$];
   int         rx_t[$];
   bit         rx_ok[$];
   logic       rx_p[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign v0 = valid && (sel == 0);
   assign v1 = valid && (sel == 1);
   assign v2 = valid && (sel == 2);
   assign v3 = valid && (sel == 3);

   always_comb begin
      tx_sel = tx0; ready_sel = rdy0; wait_sel = wt0; lvl_sel = lv0;
      case (sel)
         1: begin tx_sel = tx1; ready_sel = rdy1; wait_sel = wt1; lvl_sel = lv1; end
         2: begin tx_sel = tx2; ready_sel = rdy2; wait_sel = wt2; lvl_sel = lv2; end
         3: begin tx_sel = tx3; ready_sel = rdy3; wait_sel = wt3; lvl_sel = lv3; end
         default: ;
      endcase
   end

   uart_tx_fifo_writer u0 (
      .clk(clk), .rst(rst), .data(data), .valid(v0), .ready(rdy0), .tx(tx0),
      .wait_signal(wt0), .fifo_level(lv0));
   uart_tx_fifo_writer #(.PARITY(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .data(data), .valid(v1), .ready(rdy1), .tx(tx1),
      .wait_signal(wt1), .fifo_level(lv1));
   uart_tx_fifo_writer #(.CLK_FREQ(1_000_000), .boadrate(100_000), .PARITY(2)) u2 (
      .clk(clk), .rst(rst), .data(data), .valid(v2), .ready(rdy2), .tx(tx2),
      .wait_signal(wt2), .fifo_level(lv2));
   uart_tx_fifo_writer #(.CLK_FREQ(1_000_000), .boadrate(100_000)) u3 (
      .clk(clk), .rst(rst), .data(data), .valid(v3), .ready(rdy3), .tx(tx3),
      .wait_signal(wt3), .fifo_level(lv3));

   task automatic select(input int s);
      sel = s;
      cfg_nb = 8;
      case (s)
         0: begin cfg_div = 434; cfg_par = 0; cfg_stop = 1; end
         1: begin cfg_div = 434; cfg_par = 1; cfg_stop = 2; end
         2: begin cfg_div = 10;  cfg_par = 2; cfg_stop = 1; end
         default: begin cfg_div = 10; cfg_par = 0; cfg_stop = 1; end
      endcase
   endtask

   function automatic int frame_len();
      return (1 + cfg_nb + ((cfg_par != 0) ? 1 : 0) + cfg_stop) * cfg_div;
   endfunction

   task automatic clear_rx();
      rx_w.delete(); rx_t.delete(); rx_ok.delete(); rx_p.delete();
   endtask

   // Receiver: every sample of a bit must hold one level; stop must stay high for its full length.
   task automatic rx_frame();
      logic [7:0] w;
      logic       b, pb;
      bit         ok;
      int         t0;
      t0 = cyc; w = '0; pb = 1'b0; ok = 1'b1;
      for (int s = 1; s < cfg_div; s++) begin
         @(negedge clk); if (!rst || !mon_en) return;
         if (tx_sel !== 1'b0) ok = 1'b0;
      end
      for (int i = 0; i < cfg_nb + ((cfg_par != 0) ? 1 : 0); i++) begin
         @(negedge clk); if (!rst || !mon_en) return;
         b = tx_sel;
         for (int s = 1; s < cfg_div; s++) begin
            @(negedge clk); if (!rst || !mon_en) return;
            if (tx_sel !== b) ok = 1'b0;
         end
         if (i < cfg_nb) w[i] = b;
         else pb = b;
      end
      for (int s = 0; s < cfg_stop * cfg_div; s++) begin
         @(negedge clk); if (!rst || !mon_en) return;
         if (tx_sel !== 1'b1) ok = 1'b0;
      end
      rx_w.push_back(w); rx_t.push_back(t0); rx_ok.push_back(ok); rx_p.push_back(pb);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mon_en && (rst === 1'b1) && (tx_sel === 1'b0)) rx_frame();
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
   task automatic push_word(input logic [7:0] w, input int budget, output int edge_n);
      int n;
      n = 0; data = w; valid = 1'b1;
      while ((ready_sel !== 1'b1) && (n < budget)) begin @(negedge clk); n++; end
      if (ready_sel !== 1'b1) begin edge_n = -1; return; end
      @(posedge clk); @(negedge clk);
      edge_n = cyc;
   endtask

   task automatic wait_rx(input int n, input int budget, output bit timed_out);
      int k;
      k = 0;
      while ((rx_w.size() < n) && (k < budget)) begin @(negedge clk); k++; end
      timed_out = (rx_w.size() < n);
   endtask

   task automatic test_reset();
      int lows;
      lows = 0;
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if ((tx0 & tx1 & tx2 & tx3) !== 1'b1) lows++;
      end
      total++;
      if (lows != 0) begin bad++; $display("FAIL reset_tx_steady: low samples=%0d want 0", lows); end
      for (int s = 0; s < 4; s++) begin
         select(s); #1;
         total++;
         if ({tx_sel, ready_sel, wait_sel} !== 3'b110) begin
            bad++; $display("FAIL reset_outputs dut%0d: tx/ready/wait=%b want 110", s, {tx_sel, ready_sel, wait_sel});
         end
         total++;
         if (lvl_sel !== 3'd0) begin bad++; $display("FAIL reset_level dut%0d: got %0d want 0", s, lvl_sel); end
      end
      @(negedge clk); rst = 1'b1;
      lows = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ((tx0 & tx1 & tx2 & tx3) !== 1'b1 || (wt0 | wt1 | wt2 | wt3) !== 1'b0) lows++;
      end
      total++;
      if (lows != 0) begin bad++; $display("FAIL post_reset_idle: bad samples=%0d want 0", lows); end
   endtask

   // One frame with exact start latency and wait_signal fall time.
   task automatic test_frame(input int s, input logic [7:0] w, input logic exp_pb, input string nm);
      int  e, f, t0;
      bit  to;
      @(negedge clk); select(s); clear_rx(); mon_en = 1'b1;
      @(negedge clk);
      f = frame_len();
      push_word(w, 10, e);
      valid = 1'b0;
      total++;
      if (e < 0) begin bad++; $display("FAIL %s_accept: word not accepted", nm); return; end
      total++;
      if (wait_sel !== 1'b1) begin bad++; $display("FAIL %s_wait_rise: got %b want 1", nm, wait_sel); end
      @(negedge clk);
      total++;
      if (tx_sel !== 1'b1) begin bad++; $display("FAIL %s_early_start: tx=%b at push+1, want 1", nm, tx_sel); end
      t0 = e + 2;
      while (cyc < t0 + f - 2) @(negedge clk);
      total++;
      if (wait_sel !== 1'b1) begin bad++; $display("FAIL %s_wait_in_frame: got %b want 1", nm, wait_sel); end
      while (cyc < t0 + f) @(negedge clk);
      total++;
      if ({wait_sel, tx_sel} !== 2'b01) begin
         bad++; $display("FAIL %s_frame_end: wait/tx=%b want 01 at frame end", nm, {wait_sel, tx_sel});
      end
      wait_rx(1, 5, to);
      total++;
      if (to) begin bad++; $display("FAIL %s_rx_timeout: frames=%0d want 1", nm, rx_w.size()); return; end
      total++;
      if (rx_t[0] != t0) begin bad++; $display("FAIL %s_latency: start at %0d want %0d", nm, rx_t[0], t0); end
      total++;
      if (rx_w[0] !== w || rx_ok[0] !== 1'b1) begin
         bad++; $display("FAIL %s_word: got %h ok=%b want %h ok=1", nm, rx_w[0], rx_ok[0], w);
      end
      if (cfg_par != 0) begin
         total++;
         if (rx_p[0] !== exp_pb) begin bad++; $display("FAIL %s_parity: got %b want %b", nm, rx_p[0], exp_pb); end
      end
      mon_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] ws[4];
      int  e[4];
      int  f, gap;
      bit  to;
      ws[0] = 8'h00; ws[1] = 8'h17; ws[2] = 8'h03; ws[3] = 8'hFF;
      @(negedge clk); select(3); clear_rx(); mon_en = 1'b1;
      @(negedge clk);
      f = frame_len();
      for (int k = 0; k < 4; k++) push_word(ws[k], 0, e[k]);
      valid = 1'b0;
      total++;
      if (e[0] < 0 || e[1] != e[0] + 1 || e[2] != e[0] + 2 || e[3] != e[0] + 3) begin
         bad++; $display("FAIL burst_accept: edges %0d %0d %0d %0d want consecutive", e[0], e[1], e[2], e[3]);
      end
      wait_rx(4, 4 * (f + 2) + 10, to);
      total++;
      if (to) begin bad++; $display("FAIL burst_rx_count: got %0d want 4", rx_w.size()); end
      for (int k = 0; k < rx_w.size() && k < 4; k++) begin
         total++;
         if (rx_w[k] !== ws[k] || rx_ok[k] !== 1'b1) begin
            bad++; $display("FAIL burst_word%0d: got %h ok=%b want %h ok=1", k, rx_w[k], rx_ok[k], ws[k]);
         end
         if (k > 0) begin
            gap = rx_t[k] - rx_t[k-1];
            total++;
            if (gap != f && gap != f + 1) begin
               bad++; $display("FAIL burst_spacing%0d: start-to-start %0d want %0d or %0d", k, gap, f, f + 1);
            end
         end
      end
      repeat (5) @(negedge clk);
      total++;
      if (wait_sel !== 1'b0 || lvl_sel !== 3'd0) begin
         bad++; $display("FAIL burst_drain: wait=%b level=%0d want 0 0", wait_sel, lvl_sel);
      end
      mon_en = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] ws[6];
      int  e[6];
      int  f;
      bit  to;
      for (int k = 0; k < 6; k++) ws[k] = 8'($urandom);
      @(negedge clk); select(3); clear_rx(); mon_en = 1'b1;
      @(negedge clk);
      f = frame_len();
      for (int k = 0; k < 5; k++) push_word(ws[k], 0, e[k]);
      total++;
      if (e[0] < 0 || e[4] != e[0] + 4) begin
         bad++; $display("FAIL ovf_accept5: first=%0d fifth=%0d want consecutive", e[0], e[4]);
      end
      total++;
      if (ready_sel !== 1'b0 || lvl_sel !== 3'd4) begin
         bad++; $display("FAIL ovf_full: ready=%b level=%0d want 0 4", ready_sel, lvl_sel);
      end
      push_word(ws[5], 2 * f, e[5]);
      valid = 1'b0;
      total++;
      if (e[5] != e[0] + f + 2 && e[5] != e[0] + f + 3) begin
         bad++; $display("FAIL ovf_held_word: accepted at %0d want %0d or %0d", e[5], e[0] + f + 2, e[0] + f + 3);
      end
      wait_rx(6, 6 * (f + 2) + 10, to);
      total++;
      if (to) begin bad++; $display("FAIL ovf_rx_count: got %0d want 6", rx_w.size()); end
      for (int k = 0; k < rx_w.size() && k < 6; k++) begin
         total++;
         if (rx_w[k] !== ws[k] || rx_ok[k] !== 1'b1) begin
            bad++; $display("FAIL ovf_word%0d: got %h ok=%b want %h ok=1", k, rx_w[k], rx_ok[k], ws[k]);
         end
      end
      repeat (2 * f) @(negedge clk);
      total++;
      if (rx_w.size() != 6) begin bad++; $display("FAIL ovf_no_extra: frames=%0d want 6", rx_w.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_random(input int s);
      logic [7:0] exp_q[$];
      logic [7:0] w;
      int  e, f;
      bit  to;
      @(negedge clk); select(s); clear_rx(); mon_en = 1'b1;
      @(negedge clk);
      f = frame_len();
      for (int k = 0; k < 8; k++) begin
         w = 8'($urandom);
         push_word(w, 6 * f, e);
         valid = 1'b0;
         total++;
         if (e < 0) begin bad++; $display("FAIL rand%0d_accept%0d: word %h not accepted", s, k, w); end
         else exp_q.push_back(w);
         repeat ($urandom_range(0, 2 * f)) @(negedge clk);
      end
      wait_rx(exp_q.size(), 9 * (f + 2) + 10, to);
      total++;
      if (to) begin bad++; $display("FAIL rand%0d_rx_count: got %0d want %0d", s, rx_w.size(), exp_q.size()); end
      for (int k = 0; k < rx_w.size() && k < exp_q.size(); k++) begin
         total++;
         if (rx_w[k] !== exp_q[k] || rx_ok[k] !== 1'b1) begin
            bad++; $display("FAIL rand%0d_word%0d: got %h ok=%b want %h ok=1", s, k, rx_w[k], rx_ok[k], exp_q[k]);
         end
         if (cfg_par != 0) begin
            total++;
            if (rx_p[k] !== ((^exp_q[k]) ^ (cfg_par == 2))) begin
               bad++; $display("FAIL rand%0d_parity%0d: got %b for word %h", s, k, rx_p[k], exp_q[k]);
            end
         end
      end
      mon_en = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int  e0, e1, e2, e, t0, f, errs;
      bit  to;
      @(negedge clk); select(3); clear_rx(); mon_en = 1'b1;
      @(negedge clk);
      f = frame_len();
      push_word(8'h5A, 0, e0);
      push_word(8'hC3, 0, e1);
      push_word(8'h96, 0, e2);
      valid = 1'b0;
      t0 = e0 + 2;
      while (cyc < t0 + 4 * cfg_div + cfg_div / 2) @(negedge clk);
      total++;
      if (lvl_sel !== 3'd2 || wait_sel !== 1'b1) begin
         bad++; $display("FAIL midrst_before: level=%0d wait=%b want 2 1", lvl_sel, wait_sel);
      end
      mon_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      total++;
      if ({tx_sel, ready_sel, wait_sel} !== 3'b110 || lvl_sel !== 3'd0) begin
         bad++; $display("FAIL midrst_async: tx/ready/wait=%b level=%0d want 110 0", {tx_sel, ready_sel, wait_sel}, lvl_sel);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      errs = 0;
      for (int i = 0; i < 3 * f; i++) begin
         @(negedge clk);
         if (tx_sel !== 1'b1 || wait_sel !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL midrst_quiet: activity samples=%0d want 0", errs); end
      clear_rx(); mon_en = 1'b1;
      push_word(8'hA3, 10, e);
      valid = 1'b0;
      wait_rx(1, f + 20, to);
      total++;
      if (to) begin bad++; $display("FAIL midrst_rx_timeout: frames=%0d want 1", rx_w.size()); end
      else begin
         total++;
         if (rx_w[0] !== 8'hA3 || rx_ok[0] !== 1'b1 || rx_t[0] != e + 2) begin
            bad++; $display("FAIL midrst_after: got %h ok=%b start=%0d want a3 ok=1 start=%0d", rx_w[0], rx_ok[0], rx_t[0], e + 2);
         end
      end
      repeat (5) @(negedge clk);
      total++;
      if (rx_w.size() != 1) begin bad++; $display("FAIL midrst_single: frames=%0d want 1", rx_w.size()); end
      mon_en = 1'b0;
   endtask

   initial begin : watchdog
      #800_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_frame(0, 8'h55, 1'b0, "single_8n1");
      test_frame(1, 8'h07, 1'b1, "even_2stop");
      test_frame(2, 8'h07, 1'b0, "odd_1stop");
      test_back_to_back();
      test_overflow();
      test_random(2);
      test_random(3);
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
